// File: rtl/mutex_monitor_if.sv
// Monitor bundle for mutex_monitor: observed lines in,
// debounced violation status out.
interface mutex_monitor_if #(
  parameter int N     = 2,
  parameter int CNT_W = 8
);
  logic             en;
  logic             clr;
  logic [N-1:0]     sig;
  logic             err_pulse;
  logic             err_sticky;
  logic [CNT_W-1:0] err_count;
  logic [N-1:0]     first_vec;
  logic             first_valid;
  logic             in_violation;

  modport master (
    output en, clr, sig,
    input  err_pulse, err_sticky, err_count,
    input  first_vec, first_valid, in_violation
  );

  modport slave (
    input  en, clr, sig,
    output err_pulse, err_sticky, err_count,
    output first_vec, first_valid, in_violation
  );
endinterface

// File: rtl/mutex_monitor.sv
// Mutual-exclusion checker: flags multi-hot (or, in onehot mode,
// all-zero) samples, debounced into counted episodes.
module mutex_monitor #(
  parameter int N        = 2,
  parameter int CNT_W    = 8,
  parameter int MODE     = 0,
  parameter int DEBOUNCE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  mutex_monitor_if.slave  mon
);

  localparam int PW = $clog2(N + 1);
  localparam int RW = $clog2(DEBOUNCE + 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(DEBOUNCE - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MONITOR = 2'd1;
  localparam logic [1:0] PENDING = 2'd2;
  localparam logic [1:0] FLAGGED = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [RW-1:0]    run_q, run_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [N-1:0]     first_vec_q, first_vec_d;
  logic             first_valid_q, first_valid_d;
  logic             in_violation_q, in_violation_d;
  logic [PW-1:0]    pop;
  logic             v;
  logic             decl;

  // Violation decode: population count of the sampled lines
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + PW'(mon.sig[i]);
    end
    v = (pop > PW'(1)) ||
        ((MODE == 1) && (pop == '0));
  end

  // Debounce FSM; an idle monitor evaluates the enabling sample
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    decl    = 1'b0;
    if (!mon.en) begin
      state_d = IDLE;
      run_d   = '0;
    end else begin
      unique case (1'b1)
        (state_q == IDLE),
        (state_q == MONITOR): begin
          if (!v) begin
            state_d = MONITOR;
          end else if (DEBOUNCE == 1) begin
            state_d = FLAGGED;
            decl    = 1'b1;
          end else begin
            state_d = PENDING;
            run_d   = RW'(1);
          end
        end
        (state_q == PENDING): begin
          if (!v) begin
            state_d = MONITOR;
            run_d   = '0;
          end else if (run_q == RUN_LAST) begin
            state_d = FLAGGED;
            run_d   = '0;
            decl    = 1'b1;
          end else begin
            run_d = run_q + RW'(1);
          end
        end
        (state_q == FLAGGED): begin
          if (!v) state_d = MONITOR;
        end
        default: ;
      endcase
    end
  end

  // Status update: clear first, then a same-edge declaration
  always_comb begin
    err_pulse_d    = decl;
    err_sticky_d   = err_sticky_q;
    err_count_d    = err_count_q;
    first_vec_d    = first_vec_q;
    first_valid_d  = first_valid_q;
    in_violation_d = (state_d == PENDING) ||
                     (state_d == FLAGGED);
    if (mon.en && mon.clr) begin
      err_sticky_d  = 1'b0;
      err_count_d   = '0;
      first_vec_d   = '0;
      first_valid_d = 1'b0;
    end
    if (decl) begin
      err_sticky_d = 1'b1;
      if (err_count_d != '1) begin
        err_count_d = err_count_d + CNT_W'(1);
      end
      if (!first_valid_d) begin
        first_vec_d   = mon.sig;
        first_valid_d = 1'b1;
      end
    end
  end

  // State and status registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      run_q          <= '0;
      err_pulse_q    <= 1'b0;
      err_sticky_q   <= 1'b0;
      err_count_q    <= '0;
      first_vec_q    <= '0;
      first_valid_q  <= 1'b0;
      in_violation_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      run_q          <= run_d;
      err_pulse_q    <= err_pulse_d;
      err_sticky_q   <= err_sticky_d;
      err_count_q    <= err_count_d;
      first_vec_q    <= first_vec_d;
      first_valid_q  <= first_valid_d;
      in_violation_q <= in_violation_d;
    end
  end

  assign mon.err_pulse    = err_pulse_q;
  assign mon.err_sticky   = err_sticky_q;
  assign mon.err_count    = err_count_q;
  assign mon.first_vec    = first_vec_q;
  assign mon.first_valid  = first_valid_q;
  assign mon.in_violation = in_violation_q;

endmodule
